// File: rtl/dffram_rw_p.sv
// rtl/dffram_rw_p.sv - flip-flop RAM, one R/W port with byte enables plus one read port
// A reset starts a clear sequence that zeroes every word; BUSY is high until it finishes.
module dffram_rw_p #(
  parameter int WORDS  = 32,
  parameter int WSIZE  = 4,
  parameter bit BYPASS = 1'b0,
  localparam int AW    = $clog2(WORDS)
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 EN0,
  input  logic [WSIZE-1:0]     WE0,
  input  logic [AW-1:0]        A0,
  input  logic [8*WSIZE-1:0]   Di0,
  output logic [8*WSIZE-1:0]   Do0,
  input  logic                 EN1,
  input  logic [AW-1:0]        A1,
  output logic [8*WSIZE-1:0]   Do1,
  output logic                 BUSY
);

  localparam int DW = 8 * WSIZE;
  localparam logic [AW:0]   W_LIM    = (AW+1)'(WORDS);
  localparam logic [AW-1:0] CNT_LAST = AW'(WORDS - 1);

  typedef enum logic [1:0] {
    ST_RESET,
    ST_CLEAR,
    ST_READY
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_cnt;
  logic [DW-1:0]   r_mem [WORDS];
  logic [DW-1:0]   r_do0;
  logic [DW-1:0]   r_do1;
  logic            r_busy;

  state_t          w_state_nxt;
  logic [AW-1:0]   w_cnt_nxt;
  logic            w_clr;
  logic            w_busy_nxt;
  logic            w_ready;
  logic            w_a0_ok;
  logic            w_a1_ok;
  logic            w_wr0;
  logic            w_collide;
  logic [DW-1:0]   w_rd0;
  logic [DW-1:0]   w_rd1;
  logic [DW-1:0]   w_merge;

  always_ff @(posedge CLK) begin
    r_state <= w_state_nxt;
    r_cnt   <= w_cnt_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_clr       = 1'b0;
    w_busy_nxt  = r_busy;
    if (RST) begin
      w_state_nxt = ST_RESET;
      w_cnt_nxt   = '0;
      w_busy_nxt  = 1'b1;
    end else begin
      case (r_state)
        ST_RESET, ST_CLEAR: begin
          w_clr      = 1'b1;
          w_busy_nxt = 1'b1;
          if (r_cnt == CNT_LAST) begin
            w_state_nxt = ST_READY;
            w_busy_nxt  = 1'b0;
            w_cnt_nxt   = '0;
          end else begin
            w_state_nxt = ST_CLEAR;
            w_cnt_nxt   = r_cnt + AW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Out-of-range addresses read as zero and never write.
  assign w_ready   = (r_state == ST_READY) && !RST;
  assign w_a0_ok   = ({1'b0, A0} < W_LIM);
  assign w_a1_ok   = ({1'b0, A1} < W_LIM);
  assign w_rd0     = w_a0_ok ? r_mem[A0] : '0;
  assign w_rd1     = w_a1_ok ? r_mem[A1] : '0;
  assign w_wr0     = w_ready && EN0 && w_a0_ok;
  assign w_collide = BYPASS && EN0 && (|WE0) && w_a0_ok && (A1 == A0);

  always_comb begin
    w_merge = w_rd0;
    for (int i = 0; i < WSIZE; i++) begin
      if (WE0[i]) w_merge[8*i +: 8] = Di0[8*i +: 8];
    end
  end

  always_ff @(posedge CLK) begin
    if (w_clr) begin
      r_mem[r_cnt] <= '0;
    end else if (w_wr0) begin
      for (int i = 0; i < WSIZE; i++) begin
        if (WE0[i]) r_mem[A0][8*i +: 8] <= Di0[8*i +: 8];
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_do0  <= '0;
      r_do1  <= '0;
      r_busy <= 1'b1;
    end else begin
      r_busy <= w_busy_nxt;
      r_do0  <= (w_ready && EN0) ? w_rd0 : '0;
      r_do1  <= (w_ready && EN1) ? (w_collide ? w_merge : w_rd1) : '0;
    end
  end

  assign Do0  = r_do0;
  assign Do1  = r_do1;
  assign BUSY = r_busy;

endmodule

// File: tb/tb_dffram_rw_p.sv
// tb/tb_dffram_rw_p.sv - randomized bench for dffram_rw_p against a word-array reference model
// Two instances share stimulus: 32 words without bypass, 20 words with bypass.
module tb_dffram_rw_p;

  logic        clk = 1'b0;
  logic        rst;
  logic        en0;
  logic [3:0]  we0;
  logic [4:0]  a0;
  logic [31:0] di0;
  logic        en1;
  logic [4:0]  a1;
  logic [31:0] do0_a, do1_a, do0_b, do1_b;
  logic        busy_a, busy_b;

  int checks   = 0;
  int failures = 0;

  logic [31:0] mm [2][32];
  logic [31:0] e0 [2];
  logic [31:0] e1 [2];
  logic        eb [2];
  int          left [2];

  always #5 clk = ~clk;

  dffram_rw_p #(.WORDS(32), .WSIZE(4), .BYPASS(1'b0)) u_a (
    .CLK(clk), .RST(rst), .EN0(en0), .WE0(we0), .A0(a0), .Di0(di0), .Do0(do0_a),
    .EN1(en1), .A1(a1), .Do1(do1_a), .BUSY(busy_a)
  );

  dffram_rw_p #(.WORDS(20), .WSIZE(4), .BYPASS(1'b1)) u_b (
    .CLK(clk), .RST(rst), .EN0(en0), .WE0(we0), .A0(a0), .Di0(di0), .Do0(do0_b),
    .EN1(en1), .A1(a1), .Do1(do1_b), .BUSY(busy_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference behaviour for one clock edge, computed from the current inputs.
  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int w;
      logic [31:0] old0, old1, nw;
      w = (k == 0) ? 32 : 20;
      if (rst) begin
        eb[k] = 1'b1; left[k] = w; e0[k] = '0; e1[k] = '0;
      end else if (left[k] > 0) begin
        left[k]--;
        e0[k] = '0; e1[k] = '0;
        if (left[k] == 0) begin
          eb[k] = 1'b0;
          for (int j = 0; j < 32; j++) mm[k][j] = '0;
        end
      end else begin
        old0 = (int'(a0) < w) ? mm[k][a0] : '0;
        old1 = (int'(a1) < w) ? mm[k][a1] : '0;
        nw = old0;
        for (int i = 0; i < 4; i++) if (we0[i]) nw[8*i +: 8] = di0[8*i +: 8];
        e0[k] = en0 ? old0 : '0;
        if (!en1) e1[k] = '0;
        else if (k == 1 && en0 && we0 != 0 && a1 == a0 && int'(a0) < w) e1[k] = nw;
        else e1[k] = old1;
        if (en0 && int'(a0) < w) mm[k][a0] = nw;
      end
    end
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk);
    #1;
    check({tag, ".do0a"}, do0_a, e0[0]);
    check({tag, ".do1a"}, do1_a, e1[0]);
    check({tag, ".busya"}, {31'd0, busy_a}, {31'd0, eb[0]});
    check({tag, ".do0b"}, do0_b, e0[1]);
    check({tag, ".do1b"}, do1_b, e1[1]);
    check({tag, ".busyb"}, {31'd0, busy_b}, {31'd0, eb[1]});
  endtask

  task automatic rand_inputs(input bit allow_rst);
    rst = allow_rst && ($urandom_range(0, 199) == 0);
    en0 = ($urandom_range(0, 3) != 0);
    we0 = ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0;
    a0  = 5'($urandom);
    di0 = $urandom;
    en1 = ($urandom_range(0, 3) != 0);
    a1  = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom);
  endtask

  task automatic count_clear(input string tag);
    int n;
    n = 0;
    do begin
      rand_inputs(1'b0);
      step(tag);
      n++;
    end while (busy_a && n < 100);
    check({tag, ".edges"}, n, 32);
  endtask

  task automatic set_idle();
    rst = 1'b0; en0 = 1'b0; we0 = 4'h0; a0 = '0; di0 = '0; en1 = 1'b0; a1 = '0;
  endtask

  task automatic sweep(input string tag);
    for (int i = 0; i < 32; i++) begin
      en0 = 1'b1; we0 = 4'h0; a0 = 5'(i); en1 = 1'b1; a1 = 5'(31 - i);
      step(tag);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 2; k++) begin
      eb[k] = 1'b1; left[k] = 0; e0[k] = '0; e1[k] = '0;
      for (int j = 0; j < 32; j++) mm[k][j] = '0;
    end
    set_idle();
    rst = 1'b1;
    en0 = 1'b1; we0 = 4'hF; di0 = 32'hFFFF_FFFF;
    step("rst0");
    step("rst1");
    rst = 1'b0;
    count_clear("clr");
    set_idle();
    sweep("zero");

    // Byte-enable writes with read-before-write on port 0.
    en0 = 1'b1; we0 = 4'hF; a0 = 5'd5; di0 = 32'hDEAD_BEEF; en1 = 1'b0;
    step("bw1");
    we0 = 4'b0101; di0 = 32'h1122_3344;
    step("bw2");
    check("bw_old", do0_a, 32'hDEAD_BEEF);
    we0 = 4'h0;
    step("bw3");
    check("bw_merged", do0_a, 32'hDE22_BE44);

    // Same-address collision: old word without bypass, new word with bypass.
    we0 = 4'hF; a0 = 5'd3; di0 = 32'hAAAA_AAAA;
    step("col1");
    di0 = 32'h5555_5555; en1 = 1'b1; a1 = 5'd3;
    step("col2");
    check("col_nobyp", do1_a, 32'hAAAA_AAAA);
    check("col_byp", do1_b, 32'h5555_5555);

    // Disabled ports output zero and do not write.
    we0 = 4'h0;
    step("dis1");
    en0 = 1'b0; en1 = 1'b0; we0 = 4'hF; di0 = 32'hFFFF_FFFF;
    step("dis2");
    check("dis_do0", do0_a, 32'h0);
    check("dis_do1", do1_a, 32'h0);
    en0 = 1'b1; we0 = 4'h0;
    step("dis3");
    check("dis_keep", do0_a, 32'h5555_5555);

    // Address 22 is out of range for the 20-word instance.
    we0 = 4'hF; a0 = 5'd22; di0 = 32'h1234_5678;
    step("oor1");
    we0 = 4'h0; en1 = 1'b1; a1 = 5'd22;
    step("oor2");
    check("oor_do0b", do0_b, 32'h0);
    check("oor_do1b", do1_b, 32'h0);
    check("oor_do0a", do0_a, 32'h1234_5678);
    sweep("oor_sweep");

    // Reset at clear step 10 restarts the full clear.
    rst = 1'b1;
    step("mrst0");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_inputs(1'b0);
      step("mclr");
    end
    rst = 1'b1;
    step("mrst1");
    rst = 1'b0;
    count_clear("mclr2");
    set_idle();
    sweep("mzero");

    for (int i = 0; i < 600; i++) begin
      rand_inputs(1'b1);
      step("rnd");
    end
    set_idle();
    for (int i = 0; i < 40; i++) step("tail");
    sweep("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dffram_rw_p.md
# dffram_rw_p

Parametrised flip-flop RAM, successor to the fixed 8x32 single-port macro-style block. It has one read/write port with byte write enables, plus an independent read-only port. On reset it runs a hardware clear sequence that zeroes every word. A BUSY flag reports when the clear is running. It is used as scratch/register-file storage inside the tile, wherever a small RAM needs a second read path and a defined power-up content.

## Interface
Parameters:
- WORDS, 32, number of words; any value ≥ 2, not required to be a power of two.
- WSIZE, 4, bytes per word; data width is 8*WSIZE.
- BYPASS, 0, same-address behaviour of port 1 during a port-0 write: 0 returns old data, 1 returns newly written data.
- AW, clog2(WORDS), address width (derived; not overridden).

Ports:
- CLK  in  1  clock; everything is sampled on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- EN0  in  1  port-0 enable.
- WE0  in  WSIZE  port-0 byte write enables; only valid with EN0.
- A0  in  AW  port-0 address.
- Di0  in  8*WSIZE  port-0 write data.
- Do0  out  8*WSIZE  port-0 read data (registered).
- EN1  in  1  port-1 read enable.
- A1  in  AW  port-1 address.
- Do1  out  8*WSIZE  port-1 read data (registered).
- BUSY  out  1  high while reset or the clear sequence is in progress.

## Operation
- State machine with three states, plus a clear counter cnt of AW bits.
  - RESET: entered on any edge where RST=1, from any state. At that edge: cnt<=0, BUSY<=1, Do0<=0, Do1<=0.
  - CLEAR: the first edge with RST=0 after RESET enters CLEAR and performs the first clear write.
  - READY: normal operation.
- Reset values: Do0=0, Do1=0, BUSY=1. Memory contents are undefined until CLEAR completes.
- CLEAR behaviour, on each edge with RST=0:
  - RAM[cnt] <= 0, then cnt <= cnt+1.
  - The write of word WORDS-1 sets BUSY<=0 and moves to READY.
  - Port inputs are ignored. Do0 and Do1 stay 0.
- Port 0 in READY, EN0=1:
  - Do0 <= RAM[A0], i.e. the contents before this edge's write (read-before-write).
  - For each i with WE0[i]=1: RAM[A0][8i+7:8i] <= Di0[8i+7:8i].
- Port 0 in READY, EN0=0: Do0<=0 and no write.
- Port 1 in READY, EN1=1: Do1 <= RAM[A1].
  - Collision case: EN0=1, WE0≠0 and A1==A0.
  - BYPASS=0: Do1 gets the old word.
  - BYPASS=1: Do1 gets the merged word (Di0 bytes where WE0[i]=1, old bytes elsewhere).
- Port 1 in READY, EN1=0: Do1<=0.
- Out-of-range address (A ≥ WORDS): the write is dropped and the read returns 0. This applies to both ports.
- Both ports may use the same address in the same cycle. Port 1 never writes, so there is no write conflict.

## Timing
- Read latency: 1 cycle on both ports. Data appears after the edge that samples EN/A.
- Write visibility: data written at edge n is visible to a read sampled at edge n+1 (and to port 1 at edge n when BYPASS=1).
- Clear duration:
  - If RST is sampled high at edge r and low from edge r+1, the clear writes occur at edges r+1 .. r+WORDS.
  - BUSY falls after edge r+WORDS.
  - The first accepted access is sampled at edge r+WORDS+1.
- RST asserted mid-CLEAR or mid-access: that edge performs no write, cnt restarts at 0, and the full clear runs again. Outputs go to 0 after that edge.
- No combinational path from any input to any output.

## Test plan
- Reset/clear: WORDS=32. Hold RST for 2 cycles, then release.
  - BUSY stays 1 for exactly 32 edges after release, then goes 0.
  - Reads of every address then return 0.
- Byte writes: write A0=5, Di0=32'hDEADBEEF, WE0=4'b1111; then WE0=4'b0101 with Di0=32'h11223344.
  - A following read of 5 returns 32'hDE22BE44.
  - The read issued alongside the second write returns 32'hDEADBEEF.
- Collision, same address on both ports:
  - RAM[3]=32'hAAAAAAAA; same edge: port 0 writes 32'h55555555 (WE0=1111) to 3, port 1 reads 3.
  - Do1 = 32'hAAAAAAAA with BYPASS=0, and 32'h55555555 with BYPASS=1.
- Disable behaviour: after a valid read, drop EN0 and EN1.
  - Next cycle Do0=Do1=0.
  - WE0=1111 with EN0=0 leaves memory unchanged.
- Out-of-range, WORDS=20: write 32'h12345678 to A0=22.
  - Reading 22 returns 0.
  - Words 0..19 are unchanged.
- Reset mid-clear: assert RST for one cycle at clear step 10.
  - BUSY stays 1 for WORDS full edges after the second release.
  - All words read 0 afterwards.
